// File: rtl/pwm_capture_pkg.sv
// Shared types and helpers for the multi-channel PWM width capture (pwm_capture_multi).
// Pure declarations: no latency and no backpressure.
package pwm_capture_pkg;

    typedef enum logic [1:0] {ARM, HIGH, LOW} chan_state_t;

    function automatic logic [63:0] cnt_max(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Low bit of channel ch inside a flattened NUM_CH*w bus.
    function automatic int unsigned fld_lo(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pwm_capture_multi_if.sv
// PWM inputs, live widths and snapshot handshake of pwm_capture_multi, channel i at [i*CNT_W +: CNT_W].
// Wires only: no latency; snapshot is req/ack with no backpressure.
interface pwm_capture_multi_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0]       pwm_in;
    logic [NUM_CH*CNT_W-1:0] high_cnt;
    logic [NUM_CH*CNT_W-1:0] low_cnt;
    logic [NUM_CH-1:0]       period_stb;
    logic [NUM_CH-1:0]       stuck;
    logic                    snap_req;
    logic                    snap_ack;
    logic [NUM_CH*CNT_W-1:0] snap_high;
    logic [NUM_CH*CNT_W-1:0] snap_low;

    modport master (
        output pwm_in, snap_req,
        input  high_cnt, low_cnt, period_stb, stuck, snap_ack, snap_high, snap_low
    );

    modport slave (
        input  pwm_in, snap_req,
        output high_cnt, low_cnt, period_stb, stuck, snap_ack, snap_high, snap_low
    );
endinterface

// File: rtl/pwm_capture_chan.sv
// One PWM channel: sync, optional glitch filter (PWM_GLITCH_FILTER_EN), ARM/HIGH/LOW width capture, stuck timeout.
// Publishes SYNC_STAGES cycles after the pin changes (+FILT_LEN with filter); never backpressures.
module pwm_capture_chan
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000000,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             period_stb,
    output logic             stuck
);
`ifdef PWM_GLITCH_FILTER_EN
    localparam int PRIME = SYNC_STAGES + 1;
`else
    localparam int PRIME = SYNC_STAGES;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);
    localparam bit               TO_EN   = (TIMEOUT_CYC != 0);

    logic [SYNC_STAGES-1:0] sync;
    logic [PRIME:0]         fill;
    logic                   s, lvl, prev, lvl_chg, rise, fall;
    logic [CNT_W-1:0]       run;
    logic                   hi_valid, timed_out;
    logic                   pub_hi, pub_lo, stb_set, tmo;
    chan_state_t            state, state_nxt;

    // fill marks when sync (and filter/prev) hold real samples, so the reset value of the chain never looks like an edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync <= '0;
            fill <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm};
            fill <= {fill[PRIME-1:0], 1'b1};
        end
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef PWM_GLITCH_FILTER_EN
    localparam int               FW        = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_LEN - 1);

    logic          filt;
    logic [FW-1:0] fcnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (!fill[PRIME-1]) begin
            filt <= s;
            fcnt <= '0;
        end else if (s == filt) begin
            fcnt <= '0;
        end else if (fcnt == FILT_LAST) begin
            filt <= s;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FW'(1);
        end
    end

    assign lvl = filt;
`else
    assign lvl = s;
`endif

    assign lvl_chg   = fill[PRIME] && (lvl != prev);
    assign rise      = lvl_chg && lvl;
    assign fall      = lvl_chg && !lvl;
    assign timed_out = TO_EN && (run == TO_VAL) && !lvl_chg;

    always_ff @(posedge clk) begin
        if (!reset) state <= ARM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pub_hi    = 1'b0;
        pub_lo    = 1'b0;
        stb_set   = 1'b0;
        tmo       = 1'b0;
        case (state)
            ARM: begin
                if (rise)      state_nxt = HIGH;
                else if (fall) state_nxt = LOW;
            end
            HIGH: begin
                if (fall) begin
                    pub_hi    = 1'b1;
                    state_nxt = LOW;
                end else if (timed_out) begin
                    tmo       = 1'b1;
                    state_nxt = ARM;
                end
            end
            LOW: begin
                if (rise) begin
                    pub_lo    = 1'b1;
                    stb_set   = hi_valid;
                    state_nxt = HIGH;
                end else if (timed_out) begin
                    tmo       = 1'b1;
                    state_nxt = ARM;
                end
            end
            default: state_nxt = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev       <= 1'b0;
            run        <= '0;
            hi_valid   <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period_stb <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            prev       <= lvl;
            run        <= lvl_chg ? CNT_W'(1) : ((run == CNT_MAX) ? run : run + CNT_W'(1));
            period_stb <= stb_set;
            if (pub_hi) high_cnt <= run;
            if (pub_lo) low_cnt  <= run;
            if (state == ARM || tmo) hi_valid <= 1'b0;
            else if (pub_hi)         hi_valid <= 1'b1;
            if (tmo)          stuck <= 1'b1;
            else if (lvl_chg) stuck <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_capture_multi.sv
// NUM_CH independent PWM width capture channels plus a coherent all-channel snapshot (filter: PWM_GLITCH_FILTER_EN).
// Widths publish SYNC_STAGES cycles after the pin edge; snap_ack one cycle after snap_req; no backpressure.
module pwm_capture_multi
    import pwm_capture_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000000,
    parameter int FILT_LEN    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pwm_capture_multi_if.slave   bus
);
    logic [NUM_CH*CNT_W-1:0] hi_w, lo_w;
    logic [NUM_CH-1:0]       stb_w, stuck_w;
    logic [NUM_CH*CNT_W-1:0] snap_hi_q, snap_lo_q;
    logic                    ack_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_capture_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .FILT_LEN    (FILT_LEN)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .pwm        (bus.pwm_in[i]),
            .high_cnt   (hi_w[fld_lo(i, CNT_W) +: CNT_W]),
            .low_cnt    (lo_w[fld_lo(i, CNT_W) +: CNT_W]),
            .period_stb (stb_w[i]),
            .stuck      (stuck_w[i])
        );
    end

    // Samples the published registers as they stood before this edge, so a same-cycle publish is excluded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            snap_hi_q <= '0;
            snap_lo_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= bus.snap_req;
            if (bus.snap_req) begin
                snap_hi_q <= hi_w;
                snap_lo_q <= lo_w;
            end
        end
    end

    assign bus.high_cnt   = hi_w;
    assign bus.low_cnt    = lo_w;
    assign bus.period_stb = stb_w;
    assign bus.stuck      = stuck_w;
    assign bus.snap_ack   = ack_q;
    assign bus.snap_high  = snap_hi_q;
    assign bus.snap_low   = snap_lo_q;

endmodule

// File: tb/tb_pwm_capture_multi.sv
// Directed bench for pwm_capture_multi: table of single-channel PWM patterns plus hand sequences
// for first-period discard, latency, timeout, saturation, snapshot coherency and mid-run reset.
module tb_pwm_capture_multi;

    localparam int CW = 32;
    localparam int TO = 100;
`ifdef PWM_GLITCH_FILTER_EN
    localparam int XL   = 4;
    localparam int MINW = 4;
`else
    localparam int XL   = 0;
    localparam int MINW = 1;
`endif
    localparam int SETTLE = 6 + XL;

    typedef struct {
        int ch;
        int hi;
        int lo;
        int per;
        int exp_hi;
        int exp_lo;
        int exp_stb;
    } vec_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   stb_cnt[3];
    int   stb_b    = 0;
    vec_t tbl[6];

    pwm_capture_multi_if #(.NUM_CH(3), .CNT_W(CW)) bus_a ();
    pwm_capture_multi_if #(.NUM_CH(1), .CNT_W(8))  bus_b ();

    pwm_capture_multi #(
        .NUM_CH(3), .CNT_W(CW), .SYNC_STAGES(2), .TIMEOUT_CYC(TO), .FILT_LEN(4)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pwm_capture_multi #(
        .NUM_CH(1), .CNT_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(0), .FILT_LEN(4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 3; i++) stb_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (bus_a.period_stb[i]) stb_cnt[i]++;
        if (bus_b.period_stb[0]) stb_b++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] hi_a(input int ch);
        return bus_a.high_cnt[ch*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] lo_a(input int ch);
        return bus_a.low_cnt[ch*CW +: CW];
    endfunction

    task automatic reset_dut();
        reset          = 1'b0;
        bus_a.pwm_in   = '0;
        bus_a.snap_req = 1'b0;
        bus_b.pwm_in   = '0;
        bus_b.snap_req = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic run_ch(input int ch, input int hi, input int lo, input int per);
        for (int p = 0; p < per; p++) begin
            bus_a.pwm_in[ch] = 1'b1;
            step(hi);
            bus_a.pwm_in[ch] = 1'b0;
            step(lo);
        end
        bus_a.pwm_in[ch] = 1'b1;
    endtask

    initial begin
        int base;
        int eh[3];
        int el[3];

        tbl[0] = '{ch: 0, hi: 10,   lo: 30,   per: 3, exp_hi: 10,   exp_lo: 30,   exp_stb: 3};
        tbl[1] = '{ch: 1, hi: 20,   lo: 20,   per: 2, exp_hi: 20,   exp_lo: 20,   exp_stb: 2};
        tbl[2] = '{ch: 2, hi: 40,   lo: 5,    per: 2, exp_hi: 40,   exp_lo: 5,    exp_stb: 2};
        tbl[3] = '{ch: 0, hi: MINW, lo: MINW, per: 3, exp_hi: MINW, exp_lo: MINW, exp_stb: 3};
        tbl[4] = '{ch: 1, hi: 15,   lo: 15,   per: 1, exp_hi: 15,   exp_lo: 15,   exp_stb: 1};
        tbl[5] = '{ch: 2, hi: 99,   lo: 99,   per: 2, exp_hi: 99,   exp_lo: 99,   exp_stb: 2};
        eh = '{10, 15, 40};
        el = '{30, 15, 5};

        reset          = 1'b0;
        bus_a.pwm_in   = '0;
        bus_a.snap_req = 1'b0;
        bus_b.pwm_in   = '0;
        bus_b.snap_req = 1'b0;
        step(3);
        chk("rst_high_cnt", bus_a.high_cnt, 0);
        chk("rst_low_cnt",  bus_a.low_cnt, 0);
        chk("rst_stb_stuck", {bus_a.period_stb, bus_a.stuck, bus_a.snap_ack}, 0);
        chk("rst_snap", {bus_a.snap_high, bus_a.snap_low}, 0);
        chk("rst_b", {bus_b.high_cnt, bus_b.low_cnt, bus_b.stuck, bus_b.period_stb}, 0);
        reset = 1'b1;

        for (int r = 0; r < 6; r++) begin
            int ch;
            reset_dut();
            ch   = tbl[r].ch;
            base = stb_cnt[ch];
            step(6);
            run_ch(ch, tbl[r].hi, tbl[r].lo, tbl[r].per);
            step(SETTLE);
            chk($sformatf("row%0d_high", r),  hi_a(ch), tbl[r].exp_hi);
            chk($sformatf("row%0d_low", r),   lo_a(ch), tbl[r].exp_lo);
            chk($sformatf("row%0d_stb", r),   stb_cnt[ch] - base, tbl[r].exp_stb);
            chk($sformatf("row%0d_stuck", r), bus_a.stuck, 0);
        end

        // period_stb latency and single-cycle width
        reset_dut();
        step(6);
        run_ch(0, 10, 30, 1);
        step(2 + XL);
        chk("lat_stb_before", bus_a.period_stb[0], 0);
        chk("lat_low_before", lo_a(0), 0);
        step(1);
        chk("lat_stb_pulse", bus_a.period_stb[0], 1);
        chk("lat_low_pub", lo_a(0), 30);
        step(1);
        chk("lat_stb_after", bus_a.period_stb[0], 0);

        // channel already high at reset release: the partial high is discarded
        reset          = 1'b0;
        bus_a.pwm_in   = 3'b010;
        step(2);
        base  = stb_cnt[1];
        reset = 1'b1;
        step(7);
        bus_a.pwm_in[1] = 1'b0;
        step(20);
        bus_a.pwm_in[1] = 1'b1;
        step(10);
        chk("arm_partial_high", hi_a(1), 0);
        chk("arm_first_low", lo_a(1), 20);
        step(10);
        bus_a.pwm_in[1] = 1'b0;
        step(20);
        bus_a.pwm_in[1] = 1'b1;
        step(SETTLE);
        chk("arm_high", hi_a(1), 20);
        chk("arm_stb", stb_cnt[1] - base, 1);

        // timeout on ch2, hold of counts, clear on next edge, no strobe after
        reset_dut();
        base = stb_cnt[2];
        step(6);
        run_ch(2, 10, 30, 1);
        step(102 + XL);
        chk("to_stuck_early", bus_a.stuck[2], 0);
        step(1);
        chk("to_stuck_set", bus_a.stuck[2], 1);
        chk("to_high_hold", hi_a(2), 10);
        chk("to_low_hold", lo_a(2), 30);
        bus_a.pwm_in[2] = 1'b0;
        step(SETTLE);
        chk("to_stuck_clr", bus_a.stuck[2], 0);
        step(20 - SETTLE);
        bus_a.pwm_in[2] = 1'b1;
        step(SETTLE);
        chk("to_low_new", lo_a(2), 20);
        chk("to_high_kept", hi_a(2), 10);
        chk("to_no_stb", stb_cnt[2] - base, 1);

        // 8-bit counter saturation with timeout disabled
        reset_dut();
        base = stb_b;
        step(6);
        bus_b.pwm_in = 1'b1;
        step(300);
        bus_b.pwm_in = 1'b0;
        step(5);
        bus_b.pwm_in = 1'b1;
        step(SETTLE);
        chk("sat_high", bus_b.high_cnt, 255);
        chk("sat_low", bus_b.low_cnt, 5);
        chk("sat_stb", stb_b - base, 1);

`ifdef PWM_GLITCH_FILTER_EN
        reset_dut();
        step(6);
        bus_a.pwm_in[0] = 1'b1;
        step(24);
        bus_a.pwm_in[0] = 1'b0;
        step(2);
        bus_a.pwm_in[0] = 1'b1;
        step(24);
        bus_a.pwm_in[0] = 1'b0;
        step(30);
        bus_a.pwm_in[0] = 1'b1;
        step(SETTLE);
        chk("glitch_high", hi_a(0), 50);
        chk("glitch_low", lo_a(0), 30);
`endif

        // all channels running concurrently, single snapshot
        reset_dut();
        step(6);
        fork
            run_ch(0, 10, 30, 2);
            run_ch(1, 15, 15, 3);
            run_ch(2, 40, 5, 2);
        join
        step(SETTLE);
        bus_a.snap_req = 1'b1;
        step(1);
        bus_a.snap_req = 1'b0;
        chk("snap_ack", bus_a.snap_ack, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("snap_high%0d", i), bus_a.snap_high[i*CW +: CW], eh[i]);
            chk($sformatf("snap_low%0d", i),  bus_a.snap_low[i*CW +: CW], el[i]);
        end
        step(1);
        chk("snap_ack_drop", bus_a.snap_ack, 0);
        chk("snap_hold", bus_a.snap_high[2*CW +: CW], 40);

        // snapshot on the same edge as a publish takes the older value
        reset_dut();
        step(6);
        run_ch(0, 12, 8, 1);
        step(20);
        bus_a.pwm_in[0] = 1'b0;
        step(2 + XL);
        bus_a.snap_req = 1'b1;
        step(1);
        bus_a.snap_req = 1'b0;
        chk("same_snap_old", bus_a.snap_high[CW-1:0], 12);
        chk("same_live_new", hi_a(0), 20);
        chk("same_ack", bus_a.snap_ack, 1);
        step(1);
        chk("same_ack_drop", bus_a.snap_ack, 0);
        bus_a.snap_req = 1'b1;
        step(1);
        chk("resnap_high", bus_a.snap_high[CW-1:0], 20);
        chk("resnap_low", bus_a.snap_low[CW-1:0], 8);
        step(1);
        chk("held_req_ack", bus_a.snap_ack, 1);
        bus_a.snap_req = 1'b0;

        // reset in the middle of operation
        reset = 1'b0;
        step(1);
        chk("mid_rst_cnts", {bus_a.high_cnt, bus_a.low_cnt}, 0);
        chk("mid_rst_snap", {bus_a.snap_high, bus_a.snap_low}, 0);
        chk("mid_rst_flags", {bus_a.period_stb, bus_a.stuck, bus_a.snap_ack}, 0);
        bus_a.pwm_in[0] = 1'b1;
        base  = stb_cnt[0];
        reset = 1'b1;
        step(8);
        bus_a.pwm_in[0] = 1'b0;
        step(10);
        bus_a.pwm_in[0] = 1'b1;
        step(SETTLE);
        chk("mid_rst_arm_high", hi_a(0), 0);
        chk("mid_rst_arm_low", lo_a(0), 10);
        chk("mid_rst_arm_stb", stb_cnt[0] - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture_multi.md
Name: pwm_capture_multi

Overview:
Parametrised multi-channel PWM pulse-width capture block for the colour-sensor path. It measures high and low widths per channel in clk cycles, exact and saturating. Each channel has an input synchroniser, a first-period discard, a per-channel stuck/timeout flag and a completed-period strobe. A snapshot handshake latches all channels in the same cycle so software reads coherent RGB values over GPIO.

Parameters:
NUM_CH, 3, number of PWM input channels
CNT_W, 32, width of every width counter/output field
SYNC_STAGES, 2, flops in the input synchroniser (min 2)
TIMEOUT_CYC, 5000000, cycles at one level before stuck asserts; 0 disables timeout
FILT_LEN, 4, glitch-filter stable-cycle requirement (used only with PWM_GLITCH_FILTER_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
pwm_in  in  NUM_CH  asynchronous PWM inputs, bit i = channel i
high_cnt  out  NUM_CH*CNT_W  live published high width, channel i at [i*CNT_W +: CNT_W]
low_cnt  out  NUM_CH*CNT_W  live published low width, same packing
period_stb  out  NUM_CH  1-cycle pulse when channel i publishes low_cnt completing a valid period
stuck  out  NUM_CH  channel i level unchanged for TIMEOUT_CYC cycles
snap_req  in  1  request coherent snapshot
snap_ack  out  1  1-cycle pulse, snapshot outputs valid
snap_high  out  NUM_CH*CNT_W  snapshot of high_cnt
snap_low  out  NUM_CH*CNT_W  snapshot of low_cnt

Behaviour:
- Reset (reset=0 at posedge clk):
  - All outputs are 0.
  - Synchronisers and prev-level registers are 0.
  - Every channel FSM goes to ARM.
  - Reset mid-operation discards any in-progress run. No strobe is produced for it.
- Level and edge detection:
  - Synchronised level s = last stage of the SYNC_STAGES chain.
  - An edge is s != prev. prev is updated every cycle.
- Run counter per channel:
  - Loads 1 on the cycle an edge is seen.
  - Otherwise increments by 1 and saturates at 2^CNT_W-1 (no wrap).
  - A published value therefore equals the exact number of cycles s held the level, capped at max.
- FSM per channel: ARM, HIGH, LOW.
  - ARM: waiting for the first edge. The partial level seen after reset or stuck is never published.
    - Rising edge -> HIGH. Falling edge -> LOW.
  - HIGH, on falling edge: high_cnt <= run, hi_valid <= 1, -> LOW.
  - LOW, on rising edge: low_cnt <= run, -> HIGH. period_stb pulses in that same cycle only if hi_valid=1.
  - hi_valid clears in ARM.
- Latency:
  - A pwm_in transition sampled at edge k makes s change at k+SYNC_STAGES-1.
  - The output register updates at posedge k+SYNC_STAGES, visible after it.
- Timeout (TIMEOUT_CYC>0):
  - When run reaches TIMEOUT_CYC in HIGH or LOW: stuck <= 1, FSM -> ARM, hi_valid <= 0.
  - high_cnt and low_cnt hold their last values.
  - stuck clears on the next edge. That edge is treated as ARM's first edge.
- Snapshot:
  - snap_req=1 at posedge t: snap_high and snap_low load the high_cnt/low_cnt values present before t, i.e. a same-cycle publish is not included. snap_ack=1 during cycle t+1.
  - snap_req held high re-snapshots every cycle, with ack every cycle.
  - Snapshot values hold otherwise.
- Channels are fully independent. Simultaneous edges on all channels are each handled in the same cycle.

Optional Feature:
PWM_GLITCH_FILTER_EN:
- When defined, a filter stage sits after the synchroniser. The filtered level changes only after the raw synced level differs from it for FILT_LEN consecutive cycles.
- Pulses shorter than FILT_LEN cycles are ignored. Latency increases by FILT_LEN cycles.
- Measured widths remain exact for pulses at least FILT_LEN cycles long, since both edges are delayed equally.
- When undefined, s feeds edge detection directly and FILT_LEN is unused.

Decomposition:
- Package pwm_capture_pkg holds:
  - Channel state enum {ARM, HIGH, LOW}.
  - Constant CNT_MAX function of CNT_W.
  - Field-slice helper for the flattened buses.
- Sub-module pwm_capture_chan: synchroniser, optional filter, edge detect, FSM, run counter, publish registers, stuck, period_stb.
- The top generates NUM_CH instances and owns the snapshot registers and snap_ack.

Test Plan:
1. ch0 driven high 10 cycles, low 30, repeated 3 periods -> first period_stb at the first rising edge after a full high; high_cnt[0]=10, low_cnt[0]=30; exactly one period_stb per period.
2. Start with ch1 already high at reset release, high 7, then 20/20 periods -> first partial 7 is never published; first published high_cnt[1]=20.
3. TIMEOUT_CYC=100, ch2 held high -> stuck[2]=1 exactly 100 cycles after the rising edge is seen; counts hold; next edge clears stuck; no period_stb for the following partial cycle.
4. CNT_W=8, TIMEOUT_CYC=0, high 300 cycles then low 5 -> high_cnt=255 (saturated), low_cnt=5.
5. Channels running at 10/30, 15/15, 40/5; snap_req pulsed once -> snap_ack next cycle; snapshot equals pre-request live values on all channels.
6. With PWM_GLITCH_FILTER_EN and FILT_LEN=4, inject a 2-cycle low glitch in a 50-cycle high -> no edge; high_cnt=50. Separately, reset asserted mid-run -> all outputs 0 next cycle, FSM in ARM.
